// File: rtl/sseg_scan_driver_if.sv
// Host-side bundle for the 4-digit seven-segment scan driver: display data in,
// multiplexed active-low digit/segment/colon drive and frame strobe out.
interface sseg_scan_driver_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        col_en;
  logic [3:0]  IO_SSEGD;
  logic [7:0]  IO_SSEG;
  logic        IO_SSEG_COL;
  logic        frame_done;

  modport master (
    output value, load, dp_in, blank, col_en,
    input  IO_SSEGD, IO_SSEG, IO_SSEG_COL, frame_done
  );

  modport slave (
    input  value, load, dp_in, blank, col_en,
    output IO_SSEGD, IO_SSEG, IO_SSEG_COL, frame_done
  );
endinterface

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with per-slot blanking guard,
// double-buffered display data (frame-atomic updates) and optional leading-zero suppression.
module sseg_scan_driver #(
  parameter int unsigned REFRESH_BITS = 16,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned LZS          = 0
) (
  input logic               M_CLOCK,
  input logic               M_RESET,
  sseg_scan_driver_if.slave bus
);

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        col;
  } frame_t;

  localparam logic [REFRESH_BITS-1:0] PreMax   = '1;
  localparam logic [REFRESH_BITS-1:0] BlankThr = REFRESH_BITS'(BLANK_CYCLES);

  logic [REFRESH_BITS-1:0] prescaler_q;
  logic [1:0]              slot_q;
  frame_t                  shadow_q;
  frame_t                  disp_q;
  frame_t                  in_frame;

  logic [3:0] ssegd_q, ssegd_d;
  logic [7:0] sseg_q, sseg_d;
  logic       col_q;
  logic       frame_done_q;

  logic       pre_wrap;
  logic       frame_end;
  logic       guard;
  logic [3:0] digit;
  logic       zero_3, zero_32, zero_321;
  logic       lzs_hit;
  logic       suppressed;

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign in_frame  = '{value: bus.value, dp: bus.dp_in, blank: bus.blank, col: bus.col_en};
  assign pre_wrap  = (prescaler_q == PreMax);
  assign frame_end = pre_wrap && (slot_q == 2'd3);
  assign guard     = (prescaler_q < BlankThr);
  assign digit     = disp_q.value[{slot_q, 2'b00} +: 4];

  // A digit is only a leading zero if every digit to its left is zero too.
  assign zero_3   = (disp_q.value[15:12] == 4'h0);
  assign zero_32  = zero_3 && (disp_q.value[11:8] == 4'h0);
  assign zero_321 = zero_32 && (disp_q.value[7:4] == 4'h0);

  always_comb begin
    lzs_hit = 1'b0;
    unique case (slot_q)
      2'd1:    lzs_hit = zero_321;
      2'd2:    lzs_hit = zero_32;
      2'd3:    lzs_hit = zero_3;
      default: lzs_hit = 1'b0;
    endcase
  end

  assign suppressed = disp_q.blank[slot_q] || ((LZS != 0) && lzs_hit);

  always_comb begin
    ssegd_d = 4'b1111;
    sseg_d  = 8'hFF;
    if (!guard && !suppressed) begin
      ssegd_d = ~(4'b0001 << slot_q);
      sseg_d  = {~disp_q.dp[slot_q], seg_lut(digit)};
    end
  end

  always_ff @(posedge M_CLOCK or posedge M_RESET) begin
    if (M_RESET) begin
      prescaler_q  <= '0;
      slot_q       <= 2'd0;
      shadow_q     <= '0;
      disp_q       <= '0;
      ssegd_q      <= 4'b1111;
      sseg_q       <= 8'hFF;
      col_q        <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q <= prescaler_q + REFRESH_BITS'(1);
      if (pre_wrap) begin
        slot_q <= slot_q + 2'd1;
      end
      if (bus.load) begin
        shadow_q <= in_frame;
      end
      // A load landing on the boundary bypasses the shadow so it is not a frame late.
      if (frame_end) begin
        disp_q <= bus.load ? in_frame : shadow_q;
      end
      ssegd_q      <= ssegd_d;
      sseg_q       <= sseg_d;
      col_q        <= ~disp_q.col;
      frame_done_q <= frame_end;
    end
  end

  assign bus.IO_SSEGD    = ssegd_q;
  assign bus.IO_SSEG     = sseg_q;
  assign bus.IO_SSEG_COL = col_q;
  assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench: two drivers (LZS off / on) at REFRESH_BITS=4, BLANK_CYCLES=2; cycle-indexed
// table of loads and expected outputs, then hand-written async-reset sequence.
module tb_sseg_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   fd0 = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sseg_scan_driver_if bus0 ();
  sseg_scan_driver_if bus1 ();

  sseg_scan_driver #(.REFRESH_BITS(4), .BLANK_CYCLES(2), .LZS(0)) dut0 (
    .M_CLOCK (clk),
    .M_RESET (rst),
    .bus     (bus0)
  );

  sseg_scan_driver #(.REFRESH_BITS(4), .BLANK_CYCLES(2), .LZS(1)) dut1 (
    .M_CLOCK (clk),
    .M_RESET (rst),
    .bus     (bus1)
  );

  typedef struct {
    int          cyc;
    int          dut;
    bit          is_load;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  blk;
    logic        col;
    logic [3:0]  e_ssegd;
    logic [7:0]  e_sseg;
    logic        e_col;
    logic        e_fd;
  } vec_t;

  vec_t tbl[$];

  task automatic ld(input int c, input int d, input logic [15:0] v, input logic [3:0] dp,
                    input logic [3:0] blk, input logic col);
    vec_t e;
    e = '{cyc: c, dut: d, is_load: 1'b1, val: v, dp: dp, blk: blk, col: col,
          e_ssegd: 4'h0, e_sseg: 8'h00, e_col: 1'b0, e_fd: 1'b0};
    tbl.push_back(e);
  endtask

  task automatic ex(input int c, input int d, input logic [3:0] sd, input logic [7:0] sg,
                    input logic col, input logic fd);
    vec_t e;
    e = '{cyc: c, dut: d, is_load: 1'b0, val: 16'h0, dp: 4'h0, blk: 4'h0, col: 1'b0,
          e_ssegd: sd, e_sseg: sg, e_col: col, e_fd: fd};
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got ssegd/sseg/col/fd=%h required %h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] outs(input int d);
    if (d == 0) return {bus0.IO_SSEGD, bus0.IO_SSEG, bus0.IO_SSEG_COL, bus0.frame_done};
    return {bus1.IO_SSEGD, bus1.IO_SSEG, bus1.IO_SSEG_COL, bus1.frame_done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    bus0.load = 1'b0;
    bus1.load = 1'b0;
    cyc++;
    if (bus0.frame_done) fd0++;
  endtask

  initial begin
    {bus0.value, bus0.load, bus0.dp_in, bus0.blank, bus0.col_en} = '0;
    {bus1.value, bus1.load, bus1.dp_in, bus1.blank, bus1.col_en} = '0;

    // cyc = post-reset edge count; outputs at cyc k reflect state index k-1.
    ex(1, 0, 4'hF, 8'hFF, 1, 0);
    ex(2, 0, 4'hF, 8'hFF, 1, 0);
    ex(3, 0, 4'hE, 8'hC0, 1, 0);
    ex(3, 1, 4'hE, 8'hC0, 1, 0);
    ld(3, 0, 16'h1234, 4'h0, 4'h0, 0);
    ld(3, 1, 16'h0040, 4'h0, 4'h0, 0);
    ex(64, 0, 4'h7, 8'hC0, 1, 1);
    ex(64, 1, 4'hF, 8'hFF, 1, 1);
    ex(65, 0, 4'hF, 8'hFF, 1, 0);
    ex(66, 0, 4'hF, 8'hFF, 1, 0);
    ex(67, 0, 4'hE, 8'h99, 1, 0);
    ex(67, 1, 4'hE, 8'hC0, 1, 0);
    ex(80, 0, 4'hE, 8'h99, 1, 0);
    ex(81, 0, 4'hF, 8'hFF, 1, 0);
    ex(83, 0, 4'hD, 8'hB0, 1, 0);
    ex(83, 1, 4'hD, 8'h99, 1, 0);
    ex(99, 0, 4'hB, 8'hA4, 1, 0);
    ex(99, 1, 4'hF, 8'hFF, 1, 0);
    ex(115, 0, 4'h7, 8'hF9, 1, 0);
    ex(115, 1, 4'hF, 8'hFF, 1, 0);
    ex(128, 0, 4'h7, 8'hF9, 1, 1);
    ex(129, 0, 4'hF, 8'hFF, 1, 0);
    ld(150, 0, 16'h0000, 4'h0, 4'h0, 0);
    ld(150, 1, 16'h0000, 4'h0, 4'h0, 0);
    ex(163, 0, 4'hB, 8'hA4, 1, 0);
    ld(165, 0, 16'hABCD, 4'h0, 4'h0, 0);
    ex(179, 0, 4'h7, 8'hF9, 1, 0);
    ex(195, 0, 4'hE, 8'hA1, 1, 0);
    ex(195, 1, 4'hE, 8'hC0, 1, 0);
    ex(211, 0, 4'hD, 8'hC6, 1, 0);
    ex(211, 1, 4'hF, 8'hFF, 1, 0);
    ex(227, 0, 4'hB, 8'h83, 1, 0);
    ex(227, 1, 4'hF, 8'hFF, 1, 0);
    ex(243, 0, 4'h7, 8'h88, 1, 0);
    ex(243, 1, 4'hF, 8'hFF, 1, 0);
    ld(255, 0, 16'h5555, 4'h0, 4'h0, 0);
    ex(256, 0, 4'h7, 8'h88, 1, 1);
    ex(259, 0, 4'hE, 8'h92, 1, 0);
    ld(270, 0, 16'h5555, 4'b0001, 4'b0100, 1);
    ex(307, 0, 4'h7, 8'h92, 1, 0);
    ex(320, 0, 4'h7, 8'h92, 1, 1);
    ex(321, 0, 4'hF, 8'hFF, 0, 0);
    ex(323, 0, 4'hE, 8'h12, 0, 0);
    ex(339, 0, 4'hD, 8'h92, 0, 0);
    ex(355, 0, 4'hF, 8'hFF, 0, 0);
    ex(362, 0, 4'hF, 8'hFF, 0, 0);
    ex(371, 0, 4'h7, 8'h92, 0, 0);
    ex(384, 0, 4'h7, 8'h92, 0, 1);

    #1 rst = 1'b1;
    repeat (2) step();
    check("reset dut0", outs(0), {4'hF, 8'hFF, 1'b1, 1'b0});
    check("reset dut1", outs(1), {4'hF, 8'hFF, 1'b1, 1'b0});
    rst = 1'b0;
    cyc = 0;
    fd0 = 0;

    foreach (tbl[i]) begin
      while (cyc < tbl[i].cyc) step();
      if (tbl[i].is_load) begin
        if (tbl[i].dut == 0) begin
          bus0.value = tbl[i].val; bus0.dp_in = tbl[i].dp;
          bus0.blank = tbl[i].blk; bus0.col_en = tbl[i].col; bus0.load = 1'b1;
        end else begin
          bus1.value = tbl[i].val; bus1.dp_in = tbl[i].dp;
          bus1.blank = tbl[i].blk; bus1.col_en = tbl[i].col; bus1.load = 1'b1;
        end
      end else begin
        check($sformatf("dut%0d cyc%0d", tbl[i].dut, tbl[i].cyc), outs(tbl[i].dut),
              {tbl[i].e_ssegd, tbl[i].e_sseg, tbl[i].e_col, tbl[i].e_fd});
      end
    end

    tests++;
    if (fd0 != 6) begin
      fails++;
      $display("FAIL frame_done count: got %0d required 6", fd0);
    end

    // Async reset mid-slot 2 (state index 419 = slot 2, prescaler 3), between clock edges.
    while (cyc < 420) step();
    #3 rst = 1'b1;
    #1;
    check("async reset dut0", outs(0), {4'hF, 8'hFF, 1'b1, 1'b0});
    check("async reset dut1", outs(1), {4'hF, 8'hFF, 1'b1, 1'b0});
    repeat (2) step();
    rst = 1'b0;
    cyc = 0;
    step();
    check("post-reset 1", outs(0), {4'hF, 8'hFF, 1'b1, 1'b0});
    step();
    check("post-reset 2", outs(0), {4'hF, 8'hFF, 1'b1, 1'b0});
    step();
    check("post-reset 3", outs(0), {4'hE, 8'hC0, 1'b1, 1'b0});
    while (cyc < 64) step();
    check("post-reset boundary", outs(0), {4'h7, 8'hC0, 1'b1, 1'b1});
    while (cyc < 67) step();
    check("shadow discarded", outs(0), {4'hE, 8'hC0, 1'b1, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sseg_scan_driver.md
SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_BITS, default 16, meaning the slot length is N = 2^REFRESH_BITS clocks per digit.
REQ-002 SHALL have parameter BLANK_CYCLES, default 64, meaning the all-digits-off guard at the start of each slot; legal range 0..N-1.
REQ-003 SHALL have parameter LZS, default 0, meaning leading-zero suppression is enabled when 1.
REQ-004 SHALL have port M_CLOCK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port M_RESET, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port value, input, 16 bits: four hex digits; digit k = value[4k+3:4k], digit 0 rightmost.
REQ-007 SHALL have port load, input, 1 bit: a single-cycle strobe that captures value, dp_in, blank and col_en.
REQ-008 SHALL have port dp_in, input, 4 bits: decimal point per digit, active-high.
REQ-009 SHALL have port blank, input, 4 bits: per-digit force-off, active-high.
REQ-010 SHALL have port col_en, input, 1 bit: colon on, active-high.
REQ-011 SHALL have port IO_SSEGD, output, 4 bits: digit enables, active-low; bit k selects digit k.
REQ-012 SHALL have port IO_SSEG, output, 8 bits: segments, active-low; 7=dp, 6=g, 5=f, 4=e, 3=d, 2=c, 1=b, 0=a.
REQ-013 SHALL have port IO_SSEG_COL, output, 1 bit: colon, active-low.
REQ-014 SHALL have port frame_done, output, 1 bit: a one-cycle pulse at the end of every full 4-digit scan.

Function
REQ-015 SHALL use a REFRESH_BITS-bit prescaler that counts 0..N-1 and wraps, plus a 2-bit slot index that advances 0,1,2,3,0 on each wrap.
REQ-016 SHALL capture value/dp_in/blank/col_en into a shadow register on every cycle where load=1; the last load wins.
REQ-017 SHALL copy shadow to the display register on the cycle where prescaler=N-1 and slot=3 (frame boundary); the display SHALL never change mid-frame.
REQ-018 SHALL, when load=1 coincides with the frame boundary, write the incoming inputs directly into both shadow and display.
REQ-019 SHALL register all outputs; outputs in a given cycle reflect prescaler/slot/display state of the previous cycle (1-cycle latency).
REQ-020 SHALL drive, in slot s with prescaler < BLANK_CYCLES, IO_SSEGD=4'b1111 and IO_SSEG=8'hFF.
REQ-021 SHALL drive, in slot s with prescaler >= BLANK_CYCLES, IO_SSEGD = ~(1<<s) and IO_SSEG = {~dp[s], seg(digit s)}, unless digit s is suppressed.
REQ-022 SHALL use seg() (bits g..a, active-low) as follows: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
REQ-023 SHALL treat digit s as suppressed when display blank[s]=1, or when LZS=1, s>=1, and digits s..3 are all zero; digit 0 is never suppressed by LZS.
REQ-024 SHALL, for a suppressed digit, hold IO_SSEGD=4'b1111 and IO_SSEG=8'hFF for its whole slot, including dp.
REQ-025 SHALL drive IO_SSEG_COL = ~display col_en, independent of slot and guard.
REQ-026 SHALL assert frame_done for exactly one cycle, on the output cycle following the frame boundary.
REQ-027 SHALL never assert more than one IO_SSEGD bit low in the same cycle.

Reset
REQ-028 SHALL, while M_RESET=1, force prescaler=0, slot=0, shadow=0, display=0, IO_SSEGD=4'b1111, IO_SSEG=8'hFF, IO_SSEG_COL=1 and frame_done=0, asynchronously.
REQ-029 SHALL, when reset is asserted mid-frame, discard pending shadow contents; after release, scanning restarts at slot 0, prescaler 0, with the guard interval first.

Verification (REFRESH_BITS=4, BLANK_CYCLES=2, N=16)
REQ-030 SHALL be verified by: reset, then load value=16'h1234 and run 2 frames -> the second frame shows digits 0..3 as 19,30,24,79 (low 7 bits), and IO_SSEGD cycles E,D,B,7 with 2 guard cycles of F per slot.
REQ-031 SHALL be verified by: load 16'h0000 during slot 1, then 16'hABCD during slot 2 -> the next frame shows ABCD only; no 0000 and no mixed frame.
REQ-032 SHALL be verified by: LZS=1 with value=16'h0040 -> digits 3 and 2 are fully off, digit 1 shows 19, and digit 0 shows 40; with value=16'h0000, only digit 0 is lit.
REQ-033 SHALL be verified by: load on the frame-boundary cycle with 16'h5555 -> the immediately following frame shows 5555; frame_done pulses once per 64 cycles.
REQ-034 SHALL be verified by: blank=4'b0100, dp_in=4'b0001, col_en=1 -> slot 2 stays dark, digit 0 IO_SSEG[7]=0, and IO_SSEG_COL=0 after the frame boundary.
REQ-035 SHALL be verified by: asserting M_RESET asynchronously mid-slot 2 -> all outputs go to their reset values without waiting for a clock edge, and after release the first lit digit is slot 0 at the third post-reset output cycle.
